// File: rtl/dp_ram_arb_if.sv
// Bus bundle for dp_ram_arb: the requester-side request/response signals and
// the single RAM port.
//
// Signals (directions as seen by the arbiter, modport "slave"):
//   req_valid_i [NREQ]       per-requester access request
//   req_we_i    [NREQ]       per-requester write enable (0 = read)
//   req_lock_i  [NREQ]       per-requester lock request
//   req_adr_i   [NREQ*AW]    packed addresses, requester k at [k*AW +: AW]
//   req_dat_i   [NREQ*DW]    packed write data, requester k at [k*DW +: DW]
//   req_ready_o [NREQ]       one-hot grant
//   rsp_valid_o [NREQ]       one-hot read-response strobe
//   rsp_dat_o   [DW]         shared read data
//   ram_cyc_o, ram_we_o      RAM cycle / write strobes
//   ram_adr_o   [AW]         RAM address
//   ram_dat_o   [DW]         RAM write data
//   ram_dat_i   [DW]         RAM read data, one cycle after a read cycle
// Modport "master" is the mirror image, used by whatever models the
// requesters and the RAM.
interface dp_ram_arb_if #(
    parameter int DPRAM_AW = 32,
    parameter int DPRAM_DW = 32,
    parameter int NREQ     = 4
);
    logic [NREQ-1:0]          req_valid_i;
    logic [NREQ-1:0]          req_we_i;
    logic [NREQ-1:0]          req_lock_i;
    logic [NREQ*DPRAM_AW-1:0] req_adr_i;
    logic [NREQ*DPRAM_DW-1:0] req_dat_i;
    logic [NREQ-1:0]          req_ready_o;
    logic [NREQ-1:0]          rsp_valid_o;
    logic [DPRAM_DW-1:0]      rsp_dat_o;
    logic                     ram_cyc_o;
    logic                     ram_we_o;
    logic [DPRAM_AW-1:0]      ram_adr_o;
    logic [DPRAM_DW-1:0]      ram_dat_o;
    logic [DPRAM_DW-1:0]      ram_dat_i;

    modport slave (
        input  req_valid_i, req_we_i, req_lock_i, req_adr_i, req_dat_i, ram_dat_i,
        output req_ready_o, rsp_valid_o, rsp_dat_o,
               ram_cyc_o, ram_we_o, ram_adr_o, ram_dat_o
    );

    modport master (
        output req_valid_i, req_we_i, req_lock_i, req_adr_i, req_dat_i, ram_dat_i,
        input  req_ready_o, rsp_valid_o, rsp_dat_o,
               ram_cyc_o, ram_we_o, ram_adr_o, ram_dat_o
    );
endinterface

// File: rtl/dp_ram_arb.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters, with an
// optional per-requester lock that keeps the port reserved across accesses.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   dp_ram_arb_if.slave: request/grant, read response and RAM port
//
// States:
//   ST_ARB  | round-robin search from ptr_q, first valid requester wins
//   ST_LOCK | port reserved for lock_idx_q; nobody else is granted
module dp_ram_arb #(
    parameter int DPRAM_AW = 32,
    parameter int DPRAM_DW = 32,
    parameter int NREQ     = 4
) (
    input  logic        clk,
    input  logic        rst,
    dp_ram_arb_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   lock_idx_q, lock_idx_d;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rsp_valid_q;

    // Grant selection. The search walks priorities from lowest to highest so
    // the last hit (closest to ptr_q) wins without needing a loop break.
    always_comb begin
        int            sum;
        logic [IW-1:0] cand;
        sum     = 0;
        cand    = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!rst) begin
            if (state_q == ST_LOCK) begin
                if (bus.req_valid_i[lock_idx_q]) begin
                    gnt_any = 1'b1;
                    gnt_idx = lock_idx_q;
                end
            end else begin
                for (int i = NREQ - 1; i >= 0; i--) begin
                    sum = int'(ptr_q) + i;
                    if (sum >= NREQ) sum = sum - NREQ;
                    cand = IW'(sum);
                    if (bus.req_valid_i[cand]) begin
                        gnt_any = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
        end
        gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    end

    always_comb begin
        bus.req_ready_o = gnt;
        bus.ram_cyc_o   = gnt_any;
        bus.ram_we_o    = gnt_any & bus.req_we_i[gnt_idx];
        bus.ram_adr_o   = bus.req_adr_i[int'(gnt_idx)*DPRAM_AW +: DPRAM_AW];
        bus.ram_dat_o   = bus.req_dat_i[int'(gnt_idx)*DPRAM_DW +: DPRAM_DW];
        // A response registered just before reset must not leak out while
        // reset is held, hence the combinational gate.
        bus.rsp_valid_o = rst ? '0 : rsp_valid_q;
        bus.rsp_dat_o   = bus.ram_dat_i;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        if (gnt_any) begin
            ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IW'(1);
            if (state_q == ST_ARB && bus.req_lock_i[gnt_idx]) begin
                state_d    = ST_LOCK;
                lock_idx_d = gnt_idx;
            end else if (state_q == ST_LOCK && !bus.req_lock_i[gnt_idx]) begin
                state_d = ST_ARB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            ptr_q       <= '0;
            lock_idx_q  <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_idx_q  <= lock_idx_d;
            rsp_valid_q <= gnt & ~bus.req_we_i;
        end
    end
endmodule

// File: tb/tb_dp_ram_arb.sv
module tb_dp_ram_arb;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dp_ram_arb_if #(.DPRAM_AW(AW), .DPRAM_DW(DW), .NREQ(NR)) bus_if ();

    dp_ram_arb #(.DPRAM_AW(AW), .DPRAM_DW(DW), .NREQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // RAM model: unwritten locations read back as 0x30 + address.
    logic [7:0]  mem [16];
    logic [15:0] written;
    always @(posedge clk) begin
        if (rst) begin
            written <= '0;
        end else if (bus_if.ram_cyc_o) begin
            if (bus_if.ram_we_o) begin
                mem[bus_if.ram_adr_o]     <= bus_if.ram_dat_o;
                written[bus_if.ram_adr_o] <= 1'b1;
            end else begin
                bus_if.ram_dat_i <= written[bus_if.ram_adr_o] ? mem[bus_if.ram_adr_o]
                                                              : 8'h30 + 8'(bus_if.ram_adr_o);
            end
        end
    end

    typedef struct {
        logic        rst;
        logic [3:0]  valid, we, lock;
        logic [15:0] adr;
        logic [31:0] dat;
        logic [3:0]  e_ready, e_rsp;
        logic [7:0]  e_rdat;
        logic        e_cyc, e_we;
        logic [3:0]  e_adr;
        logic [7:0]  e_wdat;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic [3:0] v, input logic [3:0] w,
                       input logic [3:0] l, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] erdy, input logic [3:0] ersp, input logic [7:0] erd,
                       input logic ecyc, input logic ewe, input logic [3:0] ea,
                       input logic [7:0] ewd);
        vec_t x;
        x.rst = r; x.valid = v; x.we = w; x.lock = l; x.adr = a; x.dat = d;
        x.e_ready = erdy; x.e_rsp = ersp; x.e_rdat = erd;
        x.e_cyc = ecyc; x.e_we = ewe; x.e_adr = ea; x.e_wdat = ewd;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic [3:0] l,
                         input logic [15:0] a, input logic [31:0] d);
        bus_if.req_valid_i = v;
        bus_if.req_we_i    = w;
        bus_if.req_lock_i  = l;
        bus_if.req_adr_i   = a;
        bus_if.req_dat_i   = d;
    endtask

    localparam logic [15:0] ADEF = 16'hBA98;

    initial begin
        bit seen;
        drive(4'h0, 4'h0, 4'h0, ADEF, 32'h0);
        //   rst valid we  lock adr       dat            rdy  rsp  rdat  cyc we adr wdat
        add(1, 4'h0, 4'h0, 4'h0, ADEF,     32'h0,        4'h0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        add(1, 4'hF, 4'h0, 4'h0, ADEF,     32'h0,        4'h0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        add(0, 4'hF, 4'h0, 4'h0, ADEF,     32'h0,        4'h1, 4'h0, 8'h00, 1, 0, 4'h8, 8'h00);
        add(0, 4'hF, 4'h0, 4'h0, ADEF,     32'h0,        4'h2, 4'h1, 8'h38, 1, 0, 4'h9, 8'h00);
        add(0, 4'hF, 4'h0, 4'h0, ADEF,     32'h0,        4'h4, 4'h2, 8'h39, 1, 0, 4'hA, 8'h00);
        add(0, 4'hF, 4'h0, 4'h0, ADEF,     32'h0,        4'h8, 4'h4, 8'h3A, 1, 0, 4'hB, 8'h00);
        add(0, 4'h0, 4'h0, 4'h0, ADEF,     32'h0,        4'h0, 4'h8, 8'h3B, 0, 0, 4'h0, 8'h00);
        add(0, 4'h0, 4'h0, 4'h0, ADEF,     32'h0,        4'h0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        // requester 2 writes A5 to 3, requester 1 reads it back
        add(0, 4'h4, 4'h4, 4'h0, 16'hB398, 32'h00A50000, 4'h4, 4'h0, 8'h00, 1, 1, 4'h3, 8'hA5);
        add(0, 4'h2, 4'h0, 4'h0, 16'hBA38, 32'h0,        4'h2, 4'h0, 8'h00, 1, 0, 4'h3, 8'h00);
        add(0, 4'h0, 4'h0, 4'h0, ADEF,     32'h0,        4'h0, 4'h2, 8'hA5, 0, 0, 4'h0, 8'h00);
        // requester 1 locked write, idle 3 cycles with others waiting, then unlocked read
        add(0, 4'h2, 4'h2, 4'h2, 16'hBA58, 32'h00001100, 4'h2, 4'h0, 8'h00, 1, 1, 4'h5, 8'h11);
        add(0, 4'hD, 4'h0, 4'h0, ADEF,     32'h0,        4'h0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        add(0, 4'hD, 4'h0, 4'h0, ADEF,     32'h0,        4'h0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        add(0, 4'hD, 4'h0, 4'h0, ADEF,     32'h0,        4'h0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        add(0, 4'hF, 4'h0, 4'h0, 16'hBA58, 32'h0,        4'h2, 4'h0, 8'h00, 1, 0, 4'h5, 8'h00);
        add(0, 4'hD, 4'h0, 4'h0, 16'hB698, 32'h0,        4'h4, 4'h2, 8'h11, 1, 0, 4'h6, 8'h00);
        add(0, 4'h0, 4'h0, 4'h0, ADEF,     32'h0,        4'h0, 4'h4, 8'h36, 0, 0, 4'h0, 8'h00);
        // requester 3 alone, continuous reads; ptr wraps to 0
        add(0, 4'h8, 4'h0, 4'h0, 16'hCA98, 32'h0,        4'h8, 4'h0, 8'h00, 1, 0, 4'hC, 8'h00);
        add(0, 4'h8, 4'h0, 4'h0, 16'hCA98, 32'h0,        4'h8, 4'h8, 8'h3C, 1, 0, 4'hC, 8'h00);
        add(0, 4'h8, 4'h0, 4'h0, 16'hCA98, 32'h0,        4'h8, 4'h8, 8'h3C, 1, 0, 4'hC, 8'h00);
        add(0, 4'h9, 4'h0, 4'h0, 16'hCA98, 32'h0,        4'h1, 4'h8, 8'h3C, 1, 0, 4'h8, 8'h00);
        add(0, 4'h0, 4'h0, 4'h0, ADEF,     32'h0,        4'h0, 4'h1, 8'h38, 0, 0, 4'h0, 8'h00);
        // read grant, then reset drops its response; requester 0 wins afterwards
        add(0, 4'h4, 4'h0, 4'h0, 16'hB698, 32'h0,        4'h4, 4'h0, 8'h00, 1, 0, 4'h6, 8'h00);
        add(1, 4'h9, 4'h0, 4'h0, ADEF,     32'h0,        4'h0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        add(0, 4'h9, 4'h0, 4'h0, ADEF,     32'h0,        4'h1, 4'h0, 8'h00, 1, 0, 4'h8, 8'h00);
        // ptr=1: requester 1 write beats requester 2 read, 2 follows
        add(0, 4'h6, 4'h2, 4'h0, 16'hB778, 32'h00007700, 4'h2, 4'h1, 8'h38, 1, 1, 4'h7, 8'h77);
        add(0, 4'h4, 4'h0, 4'h0, 16'hB778, 32'h0,        4'h4, 4'h0, 8'h00, 1, 0, 4'h7, 8'h00);
        add(0, 4'h0, 4'h0, 4'h0, ADEF,     32'h0,        4'h0, 4'h4, 8'h77, 0, 0, 4'h0, 8'h00);

        @(negedge clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            drive(vecs[i].valid, vecs[i].we, vecs[i].lock, vecs[i].adr, vecs[i].dat);
            #1;
            chk($sformatf("v%0d ready", i), 32'(bus_if.req_ready_o), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d rsp_valid", i), 32'(bus_if.rsp_valid_o), 32'(vecs[i].e_rsp));
            chk($sformatf("v%0d ram_cyc", i), 32'(bus_if.ram_cyc_o), 32'(vecs[i].e_cyc));
            chk($sformatf("v%0d ram_we", i), 32'(bus_if.ram_we_o), 32'(vecs[i].e_we));
            if (vecs[i].e_cyc)
                chk($sformatf("v%0d ram_adr", i), 32'(bus_if.ram_adr_o), 32'(vecs[i].e_adr));
            if (vecs[i].e_we)
                chk($sformatf("v%0d ram_wdat", i), 32'(bus_if.ram_dat_o), 32'(vecs[i].e_wdat));
            if (vecs[i].e_rsp != 4'h0)
                chk($sformatf("v%0d rsp_dat", i), 32'(bus_if.rsp_dat_o), 32'(vecs[i].e_rdat));
            @(negedge clk);
        end

        // Locked burst by requester 0 (ptr=3 here), then release and bounded
        // wait for the next round-robin winner.
        drive(4'h1, 4'h0, 4'h1, ADEF, 32'h0); #1;
        chk("lock0 first grant", 32'(bus_if.req_ready_o), 32'h1);
        @(negedge clk);
        drive(4'hB, 4'h0, 4'h1, ADEF, 32'h0); #1;
        chk("lock0 second grant", 32'(bus_if.req_ready_o), 32'h1);
        chk("lock0 first rsp", 32'(bus_if.rsp_valid_o), 32'h1);
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            drive(4'hA, 4'h0, 4'h0, ADEF, 32'h0); #1;
            chk($sformatf("lock0 idle%0d ready", n), 32'(bus_if.req_ready_o), 32'h0);
            @(negedge clk);
        end
        drive(4'hB, 4'h0, 4'h0, ADEF, 32'h0); #1;
        chk("lock0 release grant", 32'(bus_if.req_ready_o), 32'h1);
        @(negedge clk);
        drive(4'hA, 4'h0, 4'h0, ADEF, 32'h0);
        seen = 1'b0;
        for (int n = 0; n < 4 && !seen; n++) begin
            #1;
            if (bus_if.req_ready_o != 4'h0) begin
                seen = 1'b1;
                chk("post-lock winner", 32'(bus_if.req_ready_o), 32'h2);
                chk("post-lock latency", 32'(n), 32'h0);
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL post-lock grant timeout: got none expected 0010");
        end
        @(negedge clk);
        drive(4'h0, 4'h0, 4'h0, ADEF, 32'h0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
